// File: rtl/sam_pkg.sv
// Shared SAM definitions: rate_mode encodings, default dividers and the
// rate decision used by the timing generator, register file and sequencer.
package sam_pkg;

  localparam logic [1:0] RATE_SLOW = 2'b00;
  localparam logic [1:0] RATE_AD   = 2'b01;
  localparam logic [1:0] RATE_FAST = 2'b10;

  localparam int T_BITS_DEF   = 4;
  localparam int SLOW_DIV_DEF = 16;
  localparam int FAST_DIV_DEF = 8;

  // Fast when mode bit 1 is set, or in address-dependent mode off RAM.
  function automatic logic rate_is_fast(input logic [1:0] mode, input logic is_ram);
    return mode[1] | ((mode == RATE_AD) & ~is_ram);
  endfunction

endpackage

// File: rtl/cpu_phase_decode.sv
// Combinational decode of a cycle position into E/Q/T/Z_Source levels.
// The parent registers the results, so this sees next-state cnt/div.
module cpu_phase_decode #(
  parameter int CW       = 4,
  parameter int DW       = 5,
  parameter int T_BITS   = 4,
  parameter int SLOW_DIV = 16,
  parameter int FAST_DIV = 8
) (
  input  logic [CW-1:0]     cnt,
  input  logic [DW-1:0]     div,
  input  logic              fast,
  output logic              e,
  output logic              q,
  output logic              z,
  output logic [T_BITS-1:0] t
);

  localparam logic [T_BITS-1:0] RATIO = T_BITS'(SLOW_DIV / FAST_DIV);

  logic [DW-1:0]     c;
  logic [DW-1:0]     quarter, half;
  logic [T_BITS-1:0] cnt_t;

  // div is a multiple of 4, so the quarter points are exact shifts.
  always_comb begin
    c       = DW'(cnt);
    quarter = div >> 2;
    half    = div >> 1;
    cnt_t   = T_BITS'(cnt);
    q       = (c >= quarter) && (c < half + quarter);
    e       = (c >= half);
    z       = ~e & ~fast;
    t       = fast ? cnt_t * RATIO : cnt_t;
  end

endmodule

// File: rtl/cpu_timing_gen.sv
// SAM CPU timing generator: E/Q quadrature clocks, slot index T and
// Z_Source bus-owner select, with per-cycle rate latch and E stretch.
module cpu_timing_gen import sam_pkg::*; #(
  parameter int T_BITS   = T_BITS_DEF,
  parameter int SLOW_DIV = SLOW_DIV_DEF,
  parameter int FAST_DIV = FAST_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        rate_mode,
  input  logic              isRAM,
  input  logic              stretch_req,
  output logic              E,
  output logic              Q,
  output logic [T_BITS-1:0] T,
  output logic              Z_Source,
  output logic              cycle_start,
  output logic              is_fast
);

  localparam int CW = $clog2(SLOW_DIV);
  localparam int DW = CW + 1;

  if ((SLOW_DIV % 4) != 0 || (FAST_DIV % 4) != 0 || FAST_DIV < 4 ||
      FAST_DIV > SLOW_DIV || (SLOW_DIV % FAST_DIV) != 0 ||
      SLOW_DIV > (1 << T_BITS)) begin : g_bad_params
    $error("cpu_timing_gen: illegal SLOW_DIV/FAST_DIV/T_BITS combination");
  end

  logic [CW-1:0]     cnt, cnt_nxt;
  logic              run;          // 0 only straight out of reset
  logic [DW-1:0]     div_cur, div_nxt;
  logic              last, wrap, fast_nxt;
  logic              e_nxt, q_nxt, z_nxt;
  logic [T_BITS-1:0] t_nxt;

  // Next-state counter: advance, hold on stretch, or wrap and latch rate.
  // Out of reset the generator behaves as if at the end of a cycle, so the
  // first edge after release begins slot 0.
  always_comb begin
    div_cur  = is_fast ? DW'(FAST_DIV) : DW'(SLOW_DIV);
    last     = ~run || (DW'(cnt) == div_cur - 1'b1);
    wrap     = last && !(run && stretch_req);
    cnt_nxt  = cnt;
    fast_nxt = is_fast;
    if (wrap) begin
      cnt_nxt  = '0;
      fast_nxt = rate_is_fast(rate_mode, isRAM);
    end else if (!last) begin
      cnt_nxt  = cnt + 1'b1;
    end
    div_nxt  = fast_nxt ? DW'(FAST_DIV) : DW'(SLOW_DIV);
  end

  cpu_phase_decode #(
    .CW(CW), .DW(DW), .T_BITS(T_BITS), .SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV)
  ) u_decode (
    .cnt (cnt_nxt),
    .div (div_nxt),
    .fast(fast_nxt),
    .e   (e_nxt),
    .q   (q_nxt),
    .z   (z_nxt),
    .t   (t_nxt)
  );

  // State and registered outputs, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      run         <= 1'b0;
      is_fast     <= 1'b0;
      E           <= 1'b0;
      Q           <= 1'b0;
      T           <= '0;
      Z_Source    <= 1'b1;
      cycle_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      run         <= 1'b1;
      is_fast     <= fast_nxt;
      E           <= e_nxt;
      Q           <= q_nxt;
      T           <= t_nxt;
      Z_Source    <= z_nxt;
      cycle_start <= wrap;
    end
  end

endmodule

// File: tb/tb_cpu_timing_gen.sv
// Self-checking bench for cpu_timing_gen: directed scenarios plus a
// randomized run against a slot/length reference model.
module tb_cpu_timing_gen;
  import sam_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] rate_mode = 2'b00;
  logic       isRAM = 1'b0;
  logic       stretch_req = 1'b0;
  logic       E, Q, Z_Source, cycle_start, is_fast;
  logic [3:0] T;

  int checks = 0;
  int errors = 0;

  // Reference model: position in cycle and cycle length in master clocks.
  int m_pos = 0, m_len = 16;
  bit m_started = 0, m_fast = 0, m_cs = 0, m_rst = 1;

  cpu_timing_gen #(.T_BITS(4), .SLOW_DIV(16), .FAST_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .rate_mode(rate_mode), .isRAM(isRAM),
    .stretch_req(stretch_req), .E(E), .Q(Q), .T(T), .Z_Source(Z_Source),
    .cycle_start(cycle_start), .is_fast(is_fast)
  );

  always #5 clk = ~clk;

  wire [8:0] obs = {E, Q, T, Z_Source, cycle_start, is_fast};

  // One master clock: advance the model with the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    m_cs = 0;
    if (!rst_n) begin
      m_rst = 1; m_started = 0; m_pos = 0; m_len = 16; m_fast = 0;
    end else begin
      m_rst = 0;
      if (!m_started || (m_pos == m_len - 1 && !stretch_req)) begin
        m_started = 1; m_pos = 0; m_cs = 1;
        m_fast = rate_mode[1] || (rate_mode == RATE_AD && !isRAM);
        m_len  = m_fast ? 8 : 16;
      end else if (m_pos != m_len - 1) begin
        m_pos++;
      end
    end
    #1;
  endtask

  function automatic logic [8:0] expv();
    bit e, q;
    int t;
    if (m_rst) return 9'b0_0_0000_1_0_0;
    e = (m_pos >= m_len / 2);
    q = (m_pos >= m_len / 4) && (m_pos < 3 * m_len / 4);
    t = (m_pos * 16 / m_len) % 16;
    return {e, q, 4'(t), !m_fast && !e, m_cs, m_fast};
  endfunction

  // Step until a cycle_start is seen; ok=0 if the bound expires.
  task automatic align(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cycle_start) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int n;
    rst_n = 0; rate_mode = RATE_SLOW;
    repeat (3) step();
    checks++;
    if (obs !== 9'b0_0_0000_1_0_0)
      begin errors++; $display("FAIL reset_state got %b want %b", obs, 9'b0_0_0000_1_0_0); end
    rst_n = 1;
    step();
    checks++;
    if (cycle_start !== 1'b1 || obs !== expv())
      begin errors++; $display("FAIL reset_first_start got %b want %b", obs, expv()); end
    n = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      step(); n++;
      if (cycle_start) begin ok = 1; break; end
    end
    checks++;
    if (!ok || n != 16) begin errors++; $display("FAIL reset_period got %0d want 16", n); end
    // reset mid-cycle aborts the cycle
    repeat (5) step();
    rst_n = 0; step();
    checks++;
    if (obs !== 9'b0_0_0000_1_0_0)
      begin errors++; $display("FAIL reset_midcycle got %b want %b", obs, 9'b0_0_0000_1_0_0); end
    rst_n = 1; step();
    checks++;
    if (cycle_start !== 1'b1 || T !== 4'd0)
      begin errors++; $display("FAIL reset_restart got cs=%b T=%0d want cs=1 T=0", cycle_start, T); end
  endtask

  task automatic test_slow();
    bit ok;
    rate_mode = RATE_SLOW;
    align(ok);
    for (int k = 1; k < 32; k++) begin
      step();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL slow_k%0d got %b want %b", k, obs, expv()); end
    end
  endtask

  task automatic test_fast();
    bit ok;
    rate_mode = RATE_FAST;
    align(ok); align(ok);
    checks++;
    if (!ok || is_fast !== 1'b1) begin errors++; $display("FAIL fast_start got ok=%0d is_fast=%b want 1", ok, is_fast); end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL fast_k%0d got %b want %b", k, obs, expv()); end
      if (k < 8) begin
        checks++;
        if (T !== 4'(2 * k) || Z_Source !== 1'b0 || cycle_start !== 1'b0)
          begin errors++; $display("FAIL fast_T%0d got T=%0d Z=%b want T=%0d Z=0", k, T, Z_Source, 2 * k); end
      end
    end
    checks++;
    if (cycle_start !== 1'b1) begin errors++; $display("FAIL fast_len got cs=%b want 1 after 8", cycle_start); end
  endtask

  task automatic test_addr_dep();
    bit ok, want;
    int n;
    rate_mode = RATE_AD;
    for (int c = 0; c < 4; c++) begin
      want = (c % 2 == 0);
      isRAM = want;
      align(ok);
      n = 0; ok = 0;
      for (int i = 0; i < 40; i++) begin
        step(); n++;
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL ad_c%0d got %b want %b", c, obs, expv()); end
        if (cycle_start) begin ok = 1; break; end
        isRAM = (m_pos == m_len - 1) ? !want : 1'($urandom);
      end
      checks++;
      if (!ok || n != (want ? 16 : 8))
        begin errors++; $display("FAIL ad_len%0d got %0d want %0d", c, n, want ? 16 : 8); end
    end
  endtask

  task automatic test_mode_change();
    bit ok;
    int n;
    rate_mode = RATE_SLOW;
    align(ok);
    repeat (6) step();
    rate_mode = RATE_FAST;
    n = 6; ok = 0;
    for (int i = 0; i < 40; i++) begin
      step(); n++;
      if (cycle_start) begin ok = 1; break; end
    end
    checks++;
    if (!ok || n != 16) begin errors++; $display("FAIL modechg_cur got %0d want 16", n); end
    n = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      step(); n++;
      if (cycle_start) begin ok = 1; break; end
    end
    checks++;
    if (!ok || n != 8) begin errors++; $display("FAIL modechg_next got %0d want 8", n); end
  endtask

  task automatic test_stretch();
    bit ok;
    int ne, nt, n;
    rate_mode = RATE_SLOW; isRAM = 1;
    align(ok);
    ne = 0; nt = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL stretch_k%0d got %b want %b", i, obs, expv()); end
      if (cycle_start) begin ok = 1; break; end
      if (E) ne++;
      if (T == 4'd15) nt++;
      stretch_req = (nt >= 1 && nt < 4);
    end
    stretch_req = 0;
    checks++;
    if (!ok || ne != 11 || nt != 4)
      begin errors++; $display("FAIL stretch_hold got E=%0d T15=%0d want E=11 T15=4", ne, nt); end
    // stretch away from the last slot is ignored
    n = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      stretch_req = (T == 4'd5);
      step(); n++;
      if (cycle_start) begin ok = 1; break; end
    end
    stretch_req = 0;
    checks++;
    if (!ok || n != 16) begin errors++; $display("FAIL stretch_ignored got %0d want 16", n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) rate_mode = 2'($urandom);
      isRAM       = 1'($urandom);
      stretch_req = ($urandom_range(3) == 0);
      rst_n       = ($urandom_range(99) != 0);
      step();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL random_%0d got %b want %b", i, obs, expv()); end
    end
    rst_n = 1; stretch_req = 0;
  endtask

  initial begin
    test_reset();
    test_slow();
    test_fast();
    test_addr_dep();
    test_mode_change();
    test_stretch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_timing_gen.md
Name: cpu_timing_gen

Overview:
Parametrised successor to the SAM CPU timing generator. It produces the E/Q quadrature CPU clocks, the slot index T and the Z_Source bus-owner select from one master clock. Slow, fast and address-dependent rates are selected by a single encoded mode. Rate changes take effect only on cycle boundaries, and a stretch handshake holds E high for slow peripherals. It sits between the SAM register file (mode) and the RAM address/strobe sequencer (T, Z_Source).

Parameters:
T_BITS, 4, width of slot index T; SLOW_DIV must be ≤ 2^T_BITS
SLOW_DIV, 16, master clocks per E cycle at slow rate; multiple of 4
FAST_DIV, 8, master clocks per E cycle at fast rate; multiple of 4, ≤ SLOW_DIV, divides SLOW_DIV

Ports:
clk  in  1  master clock (14.31818 MHz nominal)
rst_n  in  1  reset, synchronous, active-low
rate_mode  in  2  00 slow, 01 address-dependent, 10/11 fast
isRAM  in  1  current CPU address decodes to RAM (sampled at cycle start)
stretch_req  in  1  hold E high at end of cycle while asserted
E  out  1  CPU E clock
Q  out  1  CPU Q clock, leads E by a quarter cycle
T  out  T_BITS  slot index, slow-scaled
Z_Source  out  1  1 = video address drives Z, 0 = CPU address
cycle_start  out  1  one-clock pulse in slot 0 of each cycle
is_fast  out  1  rate latched for the current cycle is fast

Behaviour:
- Reset (rst_n low at clk edge): cnt=0, div=SLOW_DIV, E=0, Q=0, T=0, Z_Source=1, cycle_start=0, is_fast=0. Reset mid-cycle aborts the cycle. The first cycle after release starts at slot 0 on the next edge.
- Internal counter cnt runs 0..div-1. On cnt==div-1 with no stretch, it wraps to 0.
- Rate latch at cnt==0 (cycle start): fast = rate_mode[1] | (rate_mode==01 & ~isRAM), so address-dependent mode runs ROM/IO fast and RAM slow. div <= fast ? FAST_DIV : SLOW_DIV; is_fast <= fast.
- rate_mode and isRAM changes mid-cycle are ignored until the next slot 0. There are no partial or truncated cycles.
- All outputs are registered and decoded from the next-state cnt, so they change on the same edge as cnt. No combinational output paths.
- Q high for cnt in [div/4, 3div/4). E high for cnt in [div/2, div). Both low otherwise. Duty 50% when not stretched.
- T = cnt * (SLOW_DIV/div), truncated to T_BITS. In fast cycles T steps by SLOW_DIV/FAST_DIV and visits only the even slots (default).
- Z_Source = 1 while E low in slow cycles (video DMA slot). Z_Source = 0 while E high, and always 0 in fast cycles.
- cycle_start = 1 exactly when cnt==0.
- Stretch handshake: stretch_req is sampled when cnt==div-1.
  - If high, cnt holds at div-1. E and Q keep their values (E=1, Q=0) and T holds.
  - Each further clock re-samples stretch_req. Release on the first low sample, with wrap to 0 on that edge.
  - Rate for the following cycle is latched normally at its slot 0.
- stretch_req at any other slot has no effect.
- Stretch and reset together: reset wins.

Decomposition:
- Shared package (sam_pkg): rate_mode encodings RATE_SLOW=2'b00, RATE_AD=2'b01, RATE_FAST=2'b10, and default SLOW_DIV/FAST_DIV constants. The same package serves the register file and the sequencer.
- One natural sub-module, cpu_phase_decode: combinational cnt/div to E/Q/T/Z_Source next-state decode, registered in the parent.
- Elaboration-time checks on parameter legality (multiple of 4, divisibility, range).

Test Plan:
- Reset: hold rst_n=0 for 3 clocks, mode 00 -> E=Q=0, T=0, Z_Source=1, is_fast=0. After release, first cycle_start on the next edge, then every 16 clocks.
- Slow rate, mode 00 -> per 16-clock cycle: Q rises at T=4 and falls at T=12; E rises at T=8 and falls at T=0; Z_Source=1 for T 0..7, 0 for T 8..15.
- Fast rate, mode 10 -> 8-clock cycle: T sequence 0,2,4,...,14; Q high for cnt 2..5, E high for cnt 4..7; Z_Source stays 0; is_fast=1.
- Address-dependent, mode 01, isRAM alternating 1,0 per cycle -> cycle lengths 16,8,16,8. Toggling isRAM mid-cycle does not change the current cycle length.
- Mode change mid-cycle: switch 00->10 at T=6 -> current cycle completes at 16 clocks; the next cycle is 8 clocks.
- Stretch: assert stretch_req at cnt=15 for 3 clocks in slow mode -> E high for 11 clocks, T held at 15 for 4 clocks total, then wrap to 0 with cycle_start. Stretch pulsed at T=5 -> no effect.
